// File: rtl/store_byte_insert_if.sv
// Store-request / write-beat bundle between address generation and the
// data-cache write port.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif

interface store_byte_insert_if #(
  parameter int ADDR_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_W-1:0]       in_addr;
  logic [1:0]              in_size;
  logic [`XLEN-1:0]        in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W-1:0]       out_addr;
  logic [`XLEN-1:0]        out_data;
  logic [`BYTESOFWORD-1:0] out_mask;
  logic                    out_last;

  // master issues stores and consumes beats; slave is the aligner
  modport master (
    output in_valid, in_addr, in_size, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_addr, in_size, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_mask, out_last
  );
endinterface

// File: rtl/store_byte_insert.sv
// Store-side byte-lane aligner: turns a right-aligned store into one or two
// word-aligned write beats with byte enables.
//
// state | meaning
// IDLE  | output reg empty or holding a last beat; may accept a new store
// HOLD2 | output reg holds beat 0 of a split store; beat 1 is pending
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif

module store_byte_insert #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  store_byte_insert_if.slave  bus,
  output logic [15:0]         split_cnt
);

  typedef enum logic {IDLE, HOLD2} state_t;

  state_t                  state, state_nx;
  logic                    out_valid_q, out_valid_nx;
  logic                    out_last_q, out_last_nx;
  logic [ADDR_W-1:0]       out_addr_q, out_addr_nx;
  logic [`XLEN-1:0]        out_data_q, out_data_nx;
  logic [`BYTESOFWORD-1:0] out_mask_q, out_mask_nx;
  logic [ADDR_W-1:0]       pend_addr, pend_addr_nx;
  logic [`XLEN-1:0]        pend_data, pend_data_nx;
  logic [`BYTESOFWORD-1:0] pend_mask, pend_mask_nx;
  logic [15:0]             split_cnt_nx;

  logic [1:0]              off;
  logic [3:0]              base;
  logic [7:0]              m8;
  logic [`XLEN-1:0]        sel_data;
  logic [63:0]             d64;
  logic                    split;
  logic [ADDR_W-1:0]       addr0, addr1;
  logic                    accept, fire;

  always_comb begin
    off = bus.in_addr[1:0];
    case (bus.in_size)
      2'b00:   begin base = 4'b0001; sel_data = {24'b0, bus.in_data[7:0]};  end
      2'b01:   begin base = 4'b0011; sel_data = {16'b0, bus.in_data[15:0]}; end
      default: begin base = 4'b1111; sel_data = bus.in_data;                end
    endcase
    m8    = {4'b0000, base} << off;
    d64   = {32'b0, sel_data} << {off, 3'b000};
    split = |m8[7:4];
    addr0 = {bus.in_addr[ADDR_W-1:2], 2'b00};
    addr1 = addr0 + ADDR_W'(4);
  end

  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign fire          = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;

  always_comb begin
    state_nx     = state;
    out_valid_nx = out_valid_q;
    out_last_nx  = out_last_q;
    out_addr_nx  = out_addr_q;
    out_data_nx  = out_data_q;
    out_mask_nx  = out_mask_q;
    pend_addr_nx = pend_addr;
    pend_data_nx = pend_data;
    pend_mask_nx = pend_mask;
    split_cnt_nx = split_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          out_valid_nx = 1'b1;
          out_addr_nx  = addr0;
          out_mask_nx  = m8[3:0];
          out_data_nx  = d64[31:0];
          out_last_nx  = !split;
          if (split) begin
            pend_addr_nx = addr1;
            pend_mask_nx = m8[7:4];
            pend_data_nx = d64[63:32];
            state_nx     = HOLD2;
            if (split_cnt != 16'hFFFF) split_cnt_nx = split_cnt + 16'd1;
          end
        end else if (fire) begin
          out_valid_nx = 1'b0;
        end
      end
      HOLD2: begin
        if (fire) begin
          out_addr_nx = pend_addr;
          out_mask_nx = pend_mask;
          out_data_nx = pend_data;
          out_last_nx = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      pend_addr   <= '0;
      pend_data   <= '0;
      pend_mask   <= '0;
      split_cnt   <= '0;
    end else begin
      state       <= state_nx;
      out_valid_q <= out_valid_nx;
      out_last_q  <= out_last_nx;
      out_addr_q  <= out_addr_nx;
      out_data_q  <= out_data_nx;
      out_mask_q  <= out_mask_nx;
      pend_addr   <= pend_addr_nx;
      pend_data   <= pend_data_nx;
      pend_mask   <= pend_mask_nx;
      split_cnt   <= split_cnt_nx;
    end
  end

endmodule

// File: tb/tb_store_byte_insert.sv
// Scoreboard bench for store_byte_insert: expected beats are modelled per byte
// when a store is accepted and compared as beats leave the output register.
module tb_store_byte_insert;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] split_cnt;

  store_byte_insert_if #(.ADDR_W(32)) bus ();

  store_byte_insert #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .split_cnt (split_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    exp_split = 0;

  // Byte-by-byte placement, independent of any shift arithmetic.
  function automatic void push_model(input logic [31:0] a, input logic [1:0] sz,
                                     input logic [31:0] d);
    logic [3:0]  m0, m1;
    logic [31:0] d0, d1;
    int          n, pos;
    beat_t       b;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    m0 = '0; m1 = '0; d0 = '0; d1 = '0;
    for (int k = 0; k < n; k++) begin
      pos = int'(a[1:0]) + k;
      if (pos < 4) begin
        m0[pos[1:0]] = 1'b1;
        d0[{pos[1:0], 3'b000} +: 8] = d[k*8 +: 8];
      end else begin
        m1[pos[1:0]] = 1'b1;
        d1[{pos[1:0], 3'b000} +: 8] = d[k*8 +: 8];
      end
    end
    b = '{addr: {a[31:2], 2'b00}, data: d0, mask: m0, last: (m1 == 4'b0000)};
    exp_q.push_back(b);
    if (m1 != 4'b0000) begin
      b = '{addr: {a[31:2], 2'b00} + 32'd4, data: d1, mask: m1, last: 1'b1};
      exp_q.push_back(b);
      exp_split++;
    end
  endfunction

  // Scoreboard side: every consumed beat is popped and compared.
  always @(negedge clk) begin
    beat_t got, want;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got = '{addr: bus.out_addr, data: bus.out_data, mask: bus.out_mask, last: bus.out_last};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got addr=%h data=%h mask=%b last=%b expected none",
                 got.addr, got.data, got.mask, got.last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL beat got addr=%h data=%h mask=%b last=%b expected addr=%h data=%h mask=%b last=%b",
                   got.addr, got.data, got.mask, got.last,
                   want.addr, want.data, want.mask, want.last);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int waited = 0;
    bus.in_valid = 1'b1; bus.in_addr = a; bus.in_size = sz; bus.in_data = d;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
      if (waited >= 2) bus.out_ready = 1'b1;
      @(negedge clk);
    end
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b expected 1 addr=%h", bus.in_ready, a);
    end else begin
      push_model(a, sz, d);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_size = '0; bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.out_addr, bus.out_data, bus.out_mask, split_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b last=%b addr=%h data=%h mask=%b cnt=%h expected all 0",
               bus.out_valid, bus.out_last, bus.out_addr, bus.out_data, bus.out_mask, split_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte();
    bus.out_ready = 1'b1;
    send(32'h0000_1002, 2'b00, 32'hFFFF_FFAB);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00AB_0000 || bus.out_mask !== 4'b0100) begin
      failures++;
      $display("FAIL byte_latency valid=%b data=%h mask=%b expected 1 00ab0000 0100",
               bus.out_valid, bus.out_data, bus.out_mask);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL byte_drain pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_half_split();
    bus.out_ready = 1'b1;
    send(32'h0000_1003, 2'b01, 32'h0000_1234);
    drain();
    checks++;
    if (exp_q.size() != 0 || split_cnt !== 16'(exp_split) || split_cnt !== 16'd1) begin
      failures++;
      $display("FAIL half_split pending=%0d split_cnt=%0d expected 0 and %0d",
               exp_q.size(), split_cnt, exp_split);
    end
  endtask

  task automatic test_word_backpressure();
    bus.out_ready = 1'b0;
    send(32'h0000_2001, 2'b10, 32'hDDCC_BBAA);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_mask !== 4'b1110 || bus.out_data !== 32'hCCBB_AA00 ||
          bus.out_addr !== 32'h0000_2000 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold valid=%b addr=%h mask=%b data=%h in_ready=%b expected 1 00002000 1110 ccbbaa00 0",
                 bus.out_valid, bus.out_addr, bus.out_mask, bus.out_data, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 32'(i * 4); bus.in_size = 2'b10;
      bus.in_data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || (i > 0 && bus.out_valid !== 1'b1)) begin
        failures++;
        $display("FAIL b2b_cycle%0d in_ready=%b out_valid=%b expected 1 1", i, bus.in_ready, bus.out_valid);
      end
      push_model(bus.in_addr, bus.in_size, bus.in_data);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last valid=%b last=%b expected 1 1", bus.out_valid, bus.out_last);
    end
    drain();
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFE, 2'b10, 32'h4433_2211);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      send($urandom, 2'($urandom_range(0, 3)), $urandom);
    end
    drain();
    checks++;
    if (exp_q.size() != 0 || split_cnt !== 16'(exp_split)) begin
      failures++;
      $display("FAIL random_end pending=%0d split_cnt=%0d expected 0 and %0d",
               exp_q.size(), split_cnt, exp_split);
    end
  endtask

  task automatic test_reset_mid_split();
    bus.out_ready = 1'b0;
    send(32'h0000_3003, 2'b01, 32'h0000_BEEF);
    rst_n = 1'b0;
    exp_q.delete();
    exp_split = 0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || split_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midsplit_reset out_valid=%b split_cnt=%0d expected 0 0", bus.out_valid, split_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midsplit_in_ready got %b expected 1", bus.in_ready);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midsplit_no_beat1 out_valid=%b expected 0", bus.out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte();
    test_half_split();
    test_word_backpressure();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_byte_insert.md
# store_byte_insert

Store-side byte-lane aligner for the LSU, sitting between address generation and the data-cache write port. It is the write-direction counterpart of load-side byte extraction. It takes a right-aligned store value with its byte address and size, and emits word-aligned write beats with shifted data and a byte-enable mask. A store that crosses a word boundary (misaligned half or word) is split into two beats through a small FSM, with valid/ready handshakes on both sides.

## Interface
- `ADDR_W`, default 32: byte address width. Data width is fixed by `` `XLEN `` (32). Mask width is fixed by `` `BYTESOFWORD `` (4).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: store request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_addr` input ADDR_W: byte address.
- `in_size` input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `in_data` input `` `XLEN ``: store value, right-aligned (byte in [7:0], half in [15:0]).
- `out_valid` output 1: write beat valid.
- `out_ready` input 1: beat consumed when `out_valid && out_ready`.
- `out_addr` output ADDR_W: word-aligned address, bits [1:0] always 0.
- `out_data` output `` `XLEN ``: lane-positioned write data. Disabled lanes read 0.
- `out_mask` output `` `BYTESOFWORD ``: byte enables, bit i enables out_data[8i+7:8i].
- `out_last` output 1: final beat of the current store.
- `split_cnt` output 16: saturating count of split stores since reset.

## Operation
- Decode on input handshake:
  - `off = in_addr[1:0]`.
  - Base mask is 0001 (byte), 0011 (half) or 1111 (word/11).
  - `m8 = base << off` (8 bits).
  - `d64 = zero_ext(selected bytes of in_data) << 8*off` (64 bits); unused upper bytes of in_data are zeroed first.
- Beat 0: `out_addr = {in_addr[ADDR_W-1:2],2'b00}`, `out_mask = m8[3:0]`, `out_data = d64[31:0]`.
- Beat 1 exists iff `m8[7:4] != 0`. It carries `addr = beat0_addr + 4` (mod 2^ADDR_W, wraps to 0), `mask = m8[7:4]`, `data = d64[63:32]`.
- Byte stores never split. Half stores split only at off=3. Word stores split at any off != 0.
- FSM:
  - **IDLE**:
    - Output register is empty or holds a last beat.
    - `in_ready = !out_valid || out_ready`.
    - On accept, beat 0 is loaded into the output register. If a split is needed, beat 1 is loaded into a pending register, `out_last=0`, and the state moves to HOLD2; otherwise `out_last=1`.
  - **HOLD2**:
    - Output register holds beat 0 and beat 1 is pending.
    - `in_ready = 0`.
    - On an output handshake, beat 1 is loaded into the output register with `out_last=1`, `out_valid` stays 1, and the state returns to IDLE.
- `split_cnt` increments by 1 on each accepted request that splits. It holds at 0xFFFF.
- An output handshake with no new accept in IDLE clears `out_valid`.
- Output registers hold their values while `out_valid && !out_ready`. Inputs are sampled only on the handshake.

## Timing
- Latency: beat 0 appears (`out_valid=1`) in the cycle after the input handshake.
- Throughput:
  - Non-split stores sustain 1 per cycle with `out_ready=1`, since a simultaneous out-handshake and in-accept reloads the register.
  - A split store occupies 2 output cycles; `in_ready` is low for 1 cycle under no backpressure.
- Reset (rst_n=0 at a clock edge), regardless of prior state:
  - State returns to IDLE.
  - `out_valid`, `out_last` = 0; `out_addr`, `out_data`, `out_mask` = 0; the pending register is cleared; `split_cnt` = 0.
  - `in_ready` = 1 in the first cycle after reset is released.
- Reset during HOLD2 discards both beats. There is no partial write, because beat 1 is never emitted.
- `in_ready` is combinational from `out_ready` and state. `out_*` are pure register outputs.

## Test plan
- **Byte store:** addr 0x1002, size 00, data 0xFFFFFFAB. Expect one beat: addr 0x1000, mask 0100, data 0x00AB0000, last 1, one cycle after accept.
- **Half split:** addr 0x1003, size 01, data 0x00001234. Expect beat 0 as addr 0x1000, mask 1000, data 0x34000000, last 0. Then beat 1 as addr 0x1004, mask 0001, data 0x00000012, last 1. `split_cnt` = 1.
- **Word split with backpressure:** addr 0x2001, size 10, data 0xDDCCBBAA, out_ready held 0 for 3 cycles. Beat 0 (mask 1110, data 0xCCBBAA00) must stay stable and `in_ready` must stay 0. After release, beat 1 is addr 0x2004, mask 0001, data 0x000000DD.
- **Back-to-back aligned words:** 8 consecutive words at 0x0, 0x4, … with out_ready=1. Expect 8 beats on 8 consecutive cycles, all mask 1111, last 1, `in_ready` never low.
- **Wrap:** addr 0xFFFFFFFE, size 10. Beat 0 is addr 0xFFFFFFFC, mask 1100. Beat 1 is addr 0x00000000, mask 0011.
- **Reset mid-split:** assert rst_n=0 in HOLD2. Next cycle `out_valid`=0, `split_cnt`=0, and beat 1 is never emitted. After release, `in_ready`=1.
